// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous-read memory port between the
// core load/store unit and the UART debug bridge. Each access runs the
// sequence IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP. A tie in IDLE goes
// to whichever requester did not win last time.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_stall,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              u_valid,
  input  logic              u_we,
  input  logic [ADDR_W-1:0] u_addr,
  input  logic [DATA_W-1:0] u_wdata,
  output logic              u_ready,
  output logic              u_done,
  output logic [DATA_W-1:0] u_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  // The wait counter must be able to hold MEM_LAT itself, because it steps
  // once more on the final WAIT cycle before the state moves on.
  localparam int               CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_UART = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_c_rdata;
  logic [DATA_W-1:0] r_u_rdata;

  logic              w_grant;
  logic              w_grant_uart;
  logic              w_last_wait;
  logic              w_resp_core;

  // Next-state and grant decode; a grant can only happen from IDLE.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_uart = 1'b0;
    w_last_wait  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (c_req || u_valid) begin
          w_grant      = 1'b1;
          // UART wins when it is alone, or on a tie when the core won last.
          w_grant_uart = u_valid && (!c_req || (r_last_grant == OWN_CORE));
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == CNT_LAST) begin
          w_last_wait  = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latch the winner's request and remember who won for the next tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= OWN_CORE;
      r_last_grant <= OWN_UART;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_grant) begin
      r_owner      <= w_grant_uart;
      r_last_grant <= w_grant_uart;
      r_we         <= w_grant_uart ? u_we    : c_we;
      r_addr       <= w_grant_uart ? u_addr  : c_addr;
      r_wdata      <= w_grant_uart ? u_wdata : c_wdata;
    end
  end

  // Memory latency counter: cleared in ISSUE, stepped through WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Read data lands in the owner's register on the last WAIT cycle only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c_rdata <= '0;
      r_u_rdata <= '0;
    end else if (w_last_wait && !r_we) begin
      if (r_owner == OWN_CORE) begin
        r_c_rdata <= m_rdata;
      end else begin
        r_u_rdata <= m_rdata;
      end
    end
  end

  assign w_resp_core = (r_state == S_RESP) && (r_owner == OWN_CORE);

  // Outputs. State is forced to IDLE by reset, so the state-derived strobes
  // are already low then; u_ready also looks at its inputs, so it is gated.
  assign c_stall = c_req && !w_resp_core;
  assign c_rdata = r_c_rdata;
  assign u_ready = rst && w_grant_uart;
  assign u_done  = (r_state == S_RESP) && (r_owner == OWN_UART);
  assign u_rdata = r_u_rdata;
  assign m_en    = (r_state == S_ISSUE);
  assign m_we    = m_en && r_we;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a MEM_LAT=2 instance runs the main
// sequence against a memory model; MEM_LAT=1 and MEM_LAT=7 instances check
// stall length and read capture. Memory-port transactions are predicted
// into a scoreboard and popped when m_en appears.
module tb_dmem_arbiter;

  localparam int ML  = 2;
  localparam int NSW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, c_stall;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        u_valid, u_we, u_ready, u_done;
  logic [31:0] u_addr, u_wdata, u_rdata;
  logic        m_en, m_we, busy;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int udone_n = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t sb[$];
  int   menc[$];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(ML)) u_dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_stall(c_stall), .c_rdata(c_rdata),
    .u_valid(u_valid), .u_we(u_we), .u_addr(u_addr), .u_wdata(u_wdata),
    .u_ready(u_ready), .u_done(u_done), .u_rdata(u_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  // Memory model: preset contents for a few addresses, writes override.
  logic [31:0] mem [256];
  bit   [255:0] wr_flag;
  bit   [32:0] mpipe [ML];
  logic [31:0] rd_now;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h104: return 32'h11111111;
      32'h108: return 32'h22222222;
      32'h10C: return 32'h33333333;
      32'h110: return 32'h44444444;
      32'h114: return 32'h55555555;
      32'h118: return 32'h66666666;
      default: return a ^ 32'hA5A5A5A5;
    endcase
  endfunction

  assign rd_now = wr_flag[m_addr[9:2]] ? mem[m_addr[9:2]] : init_val(m_addr);

  always @(posedge clk) begin
    if (m_en && m_we) begin
      mem[m_addr[9:2]]     <= m_wdata;
      wr_flag[m_addr[9:2]] <= 1'b1;
    end
    mpipe[0] <= {m_en && !m_we, rd_now};
    for (int i = 1; i < ML; i++) mpipe[i] <= mpipe[i-1];
  end

  // Data is only meaningful exactly MEM_LAT cycles after m_en.
  assign m_rdata = mpipe[ML-1][32] ? mpipe[ML-1][31:0] : 32'h0BADF00D;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor on the memory port.
  always @(negedge clk) begin
    txn_t e;
    if (u_done) udone_n <= udone_n + 1;
    if (rst && m_en) begin
      menc.push_back(cyc);
      check("sb_pending", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("m_we", 64'(m_we), 64'(e.we));
        check("m_addr", 64'(m_addr), 64'(e.addr));
        if (e.we) check("m_wdata", 64'(m_wdata), 64'(e.wdata));
      end
    end
  end

  // Latency sweep instances, core port only.
  logic        sw_req   [NSW];
  logic [31:0] sw_addr  [NSW];
  logic        sw_stall [NSW];
  logic [31:0] sw_rdata [NSW];
  logic        sw_quiet [NSW];
  logic        sw_busy  [NSW];

  generate
    for (genvar gi = 0; gi < NSW; gi++) begin : g_sw
      localparam int LAT = (gi == 0) ? 1 : 7;
      logic        uready, udone, men, mwe;
      logic [31:0] urdata, maddr, mwdata, mrdata;
      bit   [32:0] pipe [LAT];

      dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_sw (
        .clk(clk), .rst(rst),
        .c_req(sw_req[gi]), .c_we(1'b0), .c_addr(sw_addr[gi]), .c_wdata(32'h0),
        .c_stall(sw_stall[gi]), .c_rdata(sw_rdata[gi]),
        .u_valid(1'b0), .u_we(1'b0), .u_addr(32'h0), .u_wdata(32'h0),
        .u_ready(uready), .u_done(udone), .u_rdata(urdata),
        .m_en(men), .m_we(mwe), .m_addr(maddr), .m_wdata(mwdata),
        .m_rdata(mrdata), .busy(sw_busy[gi])
      );

      always @(posedge clk) begin
        pipe[0] <= {men && !mwe, maddr ^ 32'h5A5A0F0F};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end

      assign mrdata       = pipe[LAT-1][32] ? pipe[LAT-1][31:0] : 32'h0BADF00D;
      assign sw_quiet[gi] = !uready && !udone && !mwe && (urdata == 32'h0) && (mwdata == 32'h0);
    end
  endgenerate

  // Core access from IDLE: expects MEM_LAT+2 stall cycles, m_en in the second.
  task automatic do_core(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input string tag);
    int n = 0;
    bit done = 0;
    sb.push_back('{we, a, d});
    c_req = 1'b1; c_we = we; c_addr = a; c_wdata = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (n == 1) check({tag, "_m_en"}, 64'(m_en), 64'd1);
      if (!c_stall) begin done = 1; break; end
      n++;
      @(posedge clk); #1;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_stall_cycles"}, 64'(n), 64'(ML + 2));
    check({tag, "_c_rdata"}, 64'(c_rdata), 64'(exp_rd));
    check({tag, "_busy_resp"}, 64'(busy), 64'd1);
    $display("core %s we=%0d addr=0x%0h stall=%0d c_rdata=0x%0h", tag, we, a, n, c_rdata);
    @(posedge clk); #1;
    c_req = 1'b0; c_we = 1'b0;
  endtask

  task automatic wait_u_ready(input string tag);
    bit seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (u_ready) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic sweep_read(input int idx, input int lat, input logic [31:0] a);
    int n = 0;
    bit done = 0;
    sw_req[idx] = 1'b1; sw_addr[idx] = a;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!sw_stall[idx]) begin done = 1; break; end
      n++;
      @(posedge clk); #1;
    end
    check($sformatf("sw%0d_done", lat), 64'(done), 64'd1);
    check($sformatf("sw%0d_stall_cycles", lat), 64'(n), 64'(lat + 2));
    check($sformatf("sw%0d_rdata", lat), 64'(sw_rdata[idx]), 64'(a ^ 32'h5A5A0F0F));
    check($sformatf("sw%0d_quiet", lat), 64'(sw_quiet[idx]), 64'd1);
    $display("sweep lat=%0d addr=0x%0h stall=%0d rdata=0x%0h", lat, a, n, sw_rdata[idx]);
    @(posedge clk); #1;
    sw_req[idx] = 1'b0;
    @(negedge clk);
    check($sformatf("sw%0d_idle", lat), 64'(sw_busy[idx]), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int   ci, ui, udn, n, ud0;
    logic c_adv, u_adv;
    logic [31:0] exp_c, exp_u;

    rst = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    u_valid = 1'b1; u_we = 1'b0; u_addr = '0; u_wdata = '0;
    for (int i = 0; i < NSW; i++) begin sw_req[i] = 1'b0; sw_addr[i] = '0; end

    // Reset state with both requesters pending.
    repeat (2) @(posedge clk); #1;
    check("rst_c_stall", 64'(c_stall), 64'd1);
    check("rst_u_ready", 64'(u_ready), 64'd0);
    check("rst_u_done", 64'(u_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_m_en", 64'(m_en), 64'd0);
    check("rst_c_rdata", 64'(c_rdata), 64'd0);
    check("rst_u_rdata", 64'(u_rdata), 64'd0);
    c_req = 1'b0; u_valid = 1'b0; #1;
    check("rst_c_stall_follow", 64'(c_stall), 64'd0);
    $display("reset state checked");
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // Single core read, then a core write and read-back.
    do_core(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, "rd100");
    exp_c = 32'hDEADBEEF;
    @(negedge clk);
    check("after_rd100_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    do_core(1'b1, 32'h30, 32'h0000A5A5, exp_c, "wr30");
    do_core(1'b0, 32'h30, 32'h0, 32'h0000A5A5, "rd30");

    // Reset pulse, then a same-cycle tie: core first, UART after.
    rst = 1'b0; #1;
    check("rst2_c_rdata", 64'(c_rdata), 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h104;
    u_valid = 1'b1; u_we = 1'b0; u_addr = 32'h108;
    sb.push_back('{1'b0, 32'h104, 32'h0});
    sb.push_back('{1'b0, 32'h108, 32'h0});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("tie_u_ready_c%0d", k), 64'(u_ready), 64'd0);
      check($sformatf("tie_c_stall_c%0d", k), 64'(c_stall), 64'(k < 4));
      if (k == 4) check("tie_c_rdata", 64'(c_rdata), 64'h11111111);
      @(posedge clk); #1;
    end
    c_req = 1'b0;
    @(negedge clk);
    check("tie_u_ready_c5", 64'(u_ready), 64'd1);
    $display("tie core granted first, uart u_ready at cycle 5");
    @(posedge clk); #1; u_valid = 1'b0;
    for (int k = 6; k < 11; k++) begin
      @(negedge clk);
      check($sformatf("tie_u_done_c%0d", k), 64'(u_done), 64'(k == 9));
      if (k == 9) begin
        check("tie_u_rdata", 64'(u_rdata), 64'h22222222);
        check("tie_c_rdata_hold", 64'(c_rdata), 64'h11111111);
      end
      @(posedge clk); #1;
    end

    // Both requesters continuously pending: strict alternation.
    menc.delete();
    sb.push_back('{1'b0, 32'h10C, 32'h0});
    sb.push_back('{1'b0, 32'h114, 32'h0});
    sb.push_back('{1'b0, 32'h110, 32'h0});
    sb.push_back('{1'b0, 32'h118, 32'h0});
    ci = 0; ui = 0; udn = 0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10C;
    u_valid = 1'b1; u_we = 1'b0; u_addr = 32'h114;
    for (int k = 0; k < 80 && udn < 2; k++) begin
      @(negedge clk);
      c_adv = c_req && !c_stall;
      u_adv = u_valid && u_ready;
      if (c_adv) check($sformatf("alt_c_rdata%0d", ci), 64'(c_rdata),
                       (ci == 0) ? 64'h33333333 : 64'h44444444);
      if (u_done) begin
        check($sformatf("alt_u_rdata%0d", udn), 64'(u_rdata),
              (udn == 0) ? 64'h55555555 : 64'h66666666);
        udn++;
      end
      @(posedge clk); #1;
      if (c_adv) begin ci++; if (ci < 2) c_addr = 32'h110; else c_req = 1'b0; end
      if (u_adv) begin ui++; if (ui < 2) u_addr = 32'h118; else u_valid = 1'b0; end
    end
    check("alt_done", 64'(udn), 64'd2);
    check("alt_m_en_count", 64'(menc.size()), 64'd4);
    if (menc.size() == 4)
      for (int i = 1; i < 4; i++)
        check($sformatf("alt_m_en_gap%0d", i), 64'(menc[i] - menc[i-1]), 64'd5);
    $display("alternation: %0d accesses, core=%0d uart=%0d", menc.size(), ci, ui);
    exp_c = 32'h44444444; exp_u = 32'h66666666;

    // UART write leaves both rdata registers alone.
    sb.push_back('{1'b1, 32'h20, 32'h55});
    u_valid = 1'b1; u_we = 1'b1; u_addr = 32'h20; u_wdata = 32'h55;
    wait_u_ready("uwr_ready");
    @(posedge clk); #1; u_valid = 1'b0; u_we = 1'b0;
    n = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (u_done) break;
      n++;
      @(posedge clk); #1;
    end
    check("uwr_done_delay", 64'(n), 64'(ML + 2));
    check("uwr_c_rdata_hold", 64'(c_rdata), 64'(exp_c));
    check("uwr_u_rdata_hold", 64'(u_rdata), 64'(exp_u));
    $display("uart write addr=0x20 data=0x55 u_done after %0d cycles", n);
    @(posedge clk); #1;
    @(negedge clk);
    check("uwr_done_pulse", 64'(u_done), 64'd0);
    @(posedge clk); #1;
    do_core(1'b0, 32'h20, 32'h0, 32'h55, "rd20");

    // Reset in the middle of a UART read.
    sb.push_back('{1'b0, 32'h100, 32'h0});
    u_valid = 1'b1; u_we = 1'b0; u_addr = 32'h100;
    wait_u_ready("abort_ready");
    @(posedge clk); #1; u_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_wait", 64'(busy), 64'd1);
    ud0 = udone_n;
    rst = 1'b0; c_req = 1'b1; c_we = 1'b0; c_addr = 32'h104; #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_m_en", 64'(m_en), 64'd0);
    check("abort_m_addr", 64'(m_addr), 64'd0);
    check("abort_u_done", 64'(u_done), 64'd0);
    check("abort_c_rdata", 64'(c_rdata), 64'd0);
    check("abort_u_rdata", 64'(u_rdata), 64'd0);
    check("abort_c_stall", 64'(c_stall), 64'd1);
    repeat (3) @(posedge clk); #1;
    check("abort_no_u_done", 64'(udone_n - ud0), 64'd0);
    rst = 1'b1;
    $display("reset during WAIT: outputs cleared");
    do_core(1'b0, 32'h104, 32'h0, 32'h11111111, "post_rst");
    check("post_rst_u_rdata", 64'(u_rdata), 64'd0);
    check("post_rst_no_u_done", 64'(udone_n - ud0), 64'd0);

    // Latency sweep.
    sweep_read(0, 1, 32'h40);
    sweep_read(0, 1, 32'h44);
    sweep_read(1, 7, 32'h80);
    sweep_read(1, 7, 32'h84);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
